// File: rtl/cond_pkg.sv
// Condition-code encodings and NZCV flag bit positions shared by the
// condition evaluator and the control logic that consumes it.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = !z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = !c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = !n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = !v;
            COND_HI: CondEx = c && !z;
            COND_LS: CondEx = !c || z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = !z && (n == v);
            COND_LE: CondEx = z || (n != v);
            // 1111 has no special meaning here; it executes like AL
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/condlogic_mc.sv
// Multi-cycle condition unit: NZCV flag register, latched condition result,
// and gating of the control FSM's PC/register/memory write strobes.
module condlogic_mc
    import cond_pkg::*;
#(
    parameter int FLAGW_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic               ALUValid,
    input  logic [FLAGW_W-1:0] FlagW,
    input  logic               CondLatch,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               NoWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [3:0]         Flags,
    output logic               CondExQ
);

    logic cond_ex;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (cond_ex)
    );

    // Both updates sample the pre-edge CondExQ/Flags, so a latch and a flag
    // write on the same edge never see each other's new value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Flags   <= 4'b0000;
            CondExQ <= 1'b0;
        end else begin
            if (CondLatch)
                CondExQ <= cond_ex;
            if (ALUValid && CondExQ) begin
                if (FlagW[1]) begin
                    Flags[FLAG_N] <= ALUFlags[FLAG_N];
                    Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
                end
                if (FlagW[0]) begin
                    Flags[FLAG_C] <= ALUFlags[FLAG_C];
                    Flags[FLAG_V] <= ALUFlags[FLAG_V];
                end
            end
        end
    end

    assign PCWrite  = NextPC | (PCS & CondExQ);
    assign RegWrite = RegW & CondExQ & !NoWrite;
    assign MemWrite = MemW & CondExQ;

endmodule
